// File: rtl/line_smoother_3x3_if.sv
// Pixel stream bundle for the 3x3 line smoother: dispatcher words in, smoothed pixels and status out.
interface line_smoother_3x3_if #(
    parameter int ADDR_BITS = 10
);
    logic                 frame_start;
    logic                 bypass;
    logic                 in_we;
    logic [ADDR_BITS-1:0] in_addr;
    logic [31:0]          in_data;
    logic                 out_we;
    logic [ADDR_BITS-1:0] out_addr;
    logic [23:0]          out_data;
    logic                 busy;
    logic                 seq_err;

    modport master (output frame_start, bypass, in_we, in_addr, in_data,
                    input  out_we, out_addr, out_data, busy, seq_err);
    modport slave  (input  frame_start, bypass, in_we, in_addr, in_data,
                    output out_we, out_addr, out_data, busy, seq_err);
endinterface

// File: rtl/line_smoother_3x3.sv
// Streaming 3x3 Gaussian smoother ([1 2 1;2 4 2;1 2 1]/16) per RGB888 channel, using two
// rotating line RAMs for the previous rows. Output row lags the input row by one.
module line_smoother_3x3 #(
    parameter int H_RES     = 640,
    parameter int ADDR_BITS = 10
) (
    input logic                clk,
    input logic                reset,
    line_smoother_3x3_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LINE, FLUSH} state_t;
    localparam logic [ADDR_BITS-1:0] LAST_COL = ADDR_BITS'(H_RES - 1);

    function automatic logic [29:0] vsum(input logic [23:0] t, input logic [23:0] m,
                                         input logic [23:0] b);
        logic [29:0] s;
        for (int ch = 0; ch < 3; ch++)
            s[10*ch +: 10] = 10'(t[8*ch +: 8]) + {1'b0, m[8*ch +: 8], 1'b0} + 10'(b[8*ch +: 8]);
        return s;
    endfunction

    function automatic logic [35:0] hsum(input logic [29:0] l, input logic [29:0] c,
                                         input logic [29:0] r);
        logic [35:0] s;
        for (int ch = 0; ch < 3; ch++)
            s[12*ch +: 12] = 12'(l[10*ch +: 10]) + {1'b0, c[10*ch +: 10], 1'b0} + 12'(r[10*ch +: 10]);
        return s;
    endfunction

    function automatic logic [23:0] trunc16(input logic [35:0] s);
        logic [23:0] o;
        for (int ch = 0; ch < 3; ch++)
            o[8*ch +: 8] = s[12*ch + 4 +: 8];
        return o;
    endfunction

    state_t               state, state_nxt, st_eff;
    logic [ADDR_BITS-1:0] exp_col, exp_col_nxt;
    logic [1:0]           row_cnt, row_cnt_nxt, row_eff;
    logic                 ptr, ptr_nxt, seq_err, seq_err_nxt, acc;
    logic                 unused_hi;

    // Top byte of the dispatcher word carries no pixel data.
    assign unused_hi = ^bus.in_data[31:24];

    always_comb begin
        st_eff      = bus.frame_start ? IDLE : state;
        row_eff     = bus.frame_start ? 2'd0 : row_cnt;
        state_nxt   = st_eff;
        exp_col_nxt = exp_col;
        row_cnt_nxt = row_eff;
        ptr_nxt     = ptr;
        seq_err_nxt = bus.frame_start ? 1'b0 : seq_err;
        acc         = 1'b0;
        if (st_eff == FLUSH) state_nxt = IDLE;
        if (bus.in_we) begin
            if (st_eff == LINE) begin
                if (bus.in_addr == exp_col) begin
                    acc = 1'b1;
                end else begin
                    seq_err_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
            end else if (bus.in_addr == '0) begin
                acc       = 1'b1;
                state_nxt = LINE;
            end
        end
        if (acc) begin
            exp_col_nxt = bus.in_addr + 1'b1;
            if (bus.in_addr == LAST_COL) begin
                state_nxt = FLUSH;
                ptr_nxt   = ~ptr;
                if (row_eff != 2'd3) row_cnt_nxt = row_eff + 2'd1;
            end
        end
    end

    logic                 vld_p0, en_p0, flush_p0, vld_p1, vld_p2, vld_p3;
    logic [23:0]          rd_a_p0, rd_b_p0, bot_p0;
    logic [ADDR_BITS-1:0] col_p0, col_p1, col_p2, addr_p3;
    logic                 first_p0, old_p0;
    logic [23:0]          ram_a [H_RES];
    logic [23:0]          ram_b [H_RES];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE; exp_col <= '0; row_cnt <= 2'd0; ptr <= 1'b0; seq_err <= 1'b0;
            vld_p0 <= 1'b0; en_p0 <= 1'b0; flush_p0 <= 1'b0;
            vld_p1 <= 1'b0; vld_p2 <= 1'b0; vld_p3 <= 1'b0;
        end else begin
            state <= state_nxt; exp_col <= exp_col_nxt; row_cnt <= row_cnt_nxt;
            ptr <= ptr_nxt; seq_err <= seq_err_nxt;
            vld_p0   <= acc;
            if (acc) en_p0 <= (row_eff != 2'd0);
            flush_p0 <= (state == FLUSH) && !bus.frame_start && en_p0;
            vld_p1   <= (vld_p0 && en_p0 && col_p0 != '0) || flush_p0;
            vld_p2   <= vld_p1;
            vld_p3   <= vld_p2;
        end
    end

    // Stage p0: read-first line RAMs; the older row's RAM takes the incoming word.
    always_ff @(posedge clk) begin
        if (acc) begin
            rd_a_p0 <= ram_a[bus.in_addr];
            rd_b_p0 <= ram_b[bus.in_addr];
            if (!ptr) ram_a[bus.in_addr] <= bus.in_data[23:0];
            else      ram_b[bus.in_addr] <= bus.in_data[23:0];
            bot_p0   <= bus.in_data[23:0];
            col_p0   <= bus.in_addr;
            first_p0 <= (row_eff == 2'd1);
            old_p0   <= ptr;
        end
    end

    logic [23:0] mid_p0, top_p0, win_cpix, pix_p1, pix_p2, data_p3;
    logic [29:0] vs_p0, win_l, win_c, l_p1, c_p1, r_p1;
    logic [35:0] sum_p2;

    always_comb begin
        mid_p0 = old_p0 ? rd_a_p0 : rd_b_p0;
        top_p0 = first_p0 ? mid_p0 : (old_p0 ? rd_b_p0 : rd_a_p0);
        vs_p0  = vsum(top_p0, mid_p0, bot_p0);
    end

    // Stage p1: column window; flush reuses the pre-update window so a new col 0 never collides.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            win_l    <= (col_p0 == '0) ? vs_p0 : win_c;
            win_c    <= vs_p0;
            win_cpix <= mid_p0;
        end
        if (flush_p0) begin
            l_p1 <= win_l; c_p1 <= win_c; r_p1 <= win_c; pix_p1 <= win_cpix; col_p1 <= LAST_COL;
        end else if (vld_p0) begin
            l_p1 <= win_l; c_p1 <= win_c; r_p1 <= vs_p0; pix_p1 <= win_cpix; col_p1 <= col_p0 - 1'b1;
        end
    end

    // Stage p2: horizontal sum.
    always_ff @(posedge clk) begin
        sum_p2 <= hsum(l_p1, c_p1, r_p1);
        pix_p2 <= pix_p1;
        col_p2 <= col_p1;
    end

    // Stage p3: output register, zeroed whenever no pixel is presented.
    always_ff @(posedge clk) begin
        if (reset || !vld_p2) begin
            addr_p3 <= '0;
            data_p3 <= '0;
        end else begin
            addr_p3 <= col_p2;
            data_p3 <= bus.bypass ? pix_p2 : trunc16(sum_p2);
        end
    end

    assign bus.out_we   = vld_p3;
    assign bus.out_addr = addr_p3;
    assign bus.out_data = data_p3;
    assign bus.busy     = (state != IDLE) | vld_p0 | flush_p0 | vld_p1 | vld_p2;
    assign bus.seq_err  = seq_err;
endmodule

// File: tb/tb_line_smoother_3x3.sv
// Directed bench for line_smoother_3x3: flat, impulse, edge, bypass, sequence error, reset/gaps.
module tb_line_smoother_3x3;
    localparam int H  = 640;
    localparam int AB = 10;

    typedef struct {
        int            t;
        logic [AB-1:0] addr;
        logic [23:0]   data;
    } out_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [23:0] img [4][H];
    int   acc_t [4][H];
    out_t q[$];

    line_smoother_3x3_if #(.ADDR_BITS(AB)) bus ();
    line_smoother_3x3 #(.H_RES(H), .ADDR_BITS(AB)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.out_we === 1'b1) q.push_back('{cyc, bus.out_addr, bus.out_data});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic out_t get_q(input int i);
        out_t o;
        o.t = -1; o.addr = 'x; o.data = 'x;
        if (i < q.size()) o = q[i];
        return o;
    endfunction

    function automatic logic [23:0] ref_px(input int r, input int x, input bit byp);
        logic [23:0] res;
        int sum, rr, cc, w;
        res = '0;
        if (byp) return img[r][x];
        for (int ch = 0; ch < 3; ch++) begin
            sum = 0;
            for (int dr = -1; dr <= 1; dr++)
                for (int dc = -1; dc <= 1; dc++) begin
                    rr = (r + dr < 0) ? 0 : r + dr;
                    cc = (x + dc < 0) ? 0 : ((x + dc > H - 1) ? H - 1 : x + dc);
                    w  = (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
                    sum += w * int'(img[rr][cc][8*ch +: 8]);
                end
            res[8*ch +: 8] = 8'(sum / 16);
        end
        return res;
    endfunction

    task automatic send(input int r, input int c, input int gap);
        bus.in_we = 1'b1; bus.in_addr = AB'(c); bus.in_data = {8'hA5, img[r][c]};
        acc_t[r][c] = cyc + 1;
        @(negedge clk);
        bus.in_we = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_row(input int r, input int gmax);
        for (int c = 0; c < H; c++)
            send(r, c, (c == H - 1 || gmax == 0) ? 0 : int'($urandom_range(gmax, 0)));
    endtask

    task automatic pulse_fs();
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        q.delete();
    endtask

    task automatic drain();
        repeat (8) @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out_we"}, bus.out_we, 0);
        chk({tag, "_out_addr"}, bus.out_addr, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_seq_err"}, bus.seq_err, 0);
    endtask

    task automatic check_frame(input int nrows, input bit byp, input string tag);
        int n, r, x, t_exp;
        out_t o;
        n = (nrows - 1) * H;
        chk({tag, "_count"}, q.size(), n);
        for (int i = 0; i < n; i++) begin
            r = i / H; x = i % H;
            t_exp = (x < H - 1) ? acc_t[r + 1][x + 1] + 3 : acc_t[r + 1][H - 1] + 4;
            o = get_q(i);
            chk($sformatf("%s_r%0d_c%0d_addr", tag, r, x), o.addr, x);
            chk($sformatf("%s_r%0d_c%0d_data", tag, r, x), o.data, ref_px(r, x, byp));
            chk($sformatf("%s_r%0d_c%0d_time", tag, r, x), o.t, t_exp);
        end
    endtask

    task automatic fill_impulse();
        for (int r = 0; r < 4; r++) for (int c = 0; c < H; c++) img[r][c] = 24'h0;
        img[1][5] = 24'hFF0000;
    endtask

    initial begin
        bus.frame_start = 1'b0; bus.bypass = 1'b0; bus.in_we = 1'b0;
        bus.in_addr = '0; bus.in_data = '0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset = 1'b0;
        @(negedge clk);

        // Flat frame
        for (int r = 0; r < 4; r++) for (int c = 0; c < H; c++) img[r][c] = 24'h405060;
        pulse_fs();
        send_row(0, 0);
        chk("flat_busy_flush", bus.busy, 1);
        repeat (5) @(negedge clk);
        chk("flat_row0_no_out", q.size(), 0);
        for (int r = 1; r < 4; r++) send_row(r, 0);
        drain();
        chk("flat_busy_done", bus.busy, 0);
        chk("flat_first_px", get_q(0).data, 24'h405060);
        chk("flat_last_addr", get_q(H - 1).addr, H - 1);
        check_frame(4, 1'b0, "flat");

        // Impulse
        fill_impulse();
        pulse_fs();
        for (int r = 0; r < 4; r++) send_row(r, 0);
        drain();
        chk("imp_r1c5", get_q(H + 5).data, 24'h3F0000);
        chk("imp_r1c4", get_q(H + 4).data, 24'h1F0000);
        chk("imp_r1c6", get_q(H + 6).data, 24'h1F0000);
        chk("imp_r0c5", get_q(5).data, 24'h1F0000);
        chk("imp_r2c5", get_q(2 * H + 5).data, 24'h1F0000);
        chk("imp_r0c4", get_q(4).data, 24'h0F0000);
        chk("imp_r2c6", get_q(2 * H + 6).data, 24'h0F0000);
        chk("imp_r1c7", get_q(H + 7).data, 24'h000000);
        check_frame(4, 1'b0, "imp");

        // Left edge replicate
        for (int r = 0; r < 4; r++) for (int c = 0; c < H; c++) img[r][c] = (c == 0) ? 24'h101010 : 24'h0;
        pulse_fs();
        for (int r = 0; r < 4; r++) send_row(r, 0);
        drain();
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("edge_r%0d_c0", r), get_q(r * H).data, 24'h0C0C0C);
            chk($sformatf("edge_r%0d_c1", r), get_q(r * H + 1).data, 24'h040404);
            chk($sformatf("edge_r%0d_c2", r), get_q(r * H + 2).data, 24'h000000);
        end
        check_frame(4, 1'b0, "edge");

        // Bypass with the impulse frame
        fill_impulse();
        bus.bypass = 1'b1;
        pulse_fs();
        for (int r = 0; r < 4; r++) send_row(r, 0);
        drain();
        chk("byp_r1c5", get_q(H + 5).data, 24'hFF0000);
        chk("byp_r1c4", get_q(H + 4).data, 24'h000000);
        check_frame(4, 1'b1, "byp");
        bus.bypass = 1'b0;

        // Column jump 10 -> 12
        for (int r = 0; r < 4; r++) for (int c = 0; c < H; c++) img[r][c] = 24'h123456;
        pulse_fs();
        send_row(0, 0);
        for (int c = 0; c <= 10; c++) send(1, c, 0);
        chk("colj_seq_err_clear", bus.seq_err, 0);
        send(1, 12, 0);
        chk("colj_seq_err_set", bus.seq_err, 1);
        for (int c = 13; c < 40; c++) send(1, c, 0);
        drain();
        chk("colj_partial_count", q.size(), 10);
        chk("colj_busy", bus.busy, 0);
        send_row(1, 0);
        drain();
        chk("colj_resume_count", q.size(), 10 + H);
        chk("colj_resume_addr0", get_q(10).addr, 0);
        chk("colj_resume_data", get_q(10 + 100).data, 24'h123456);
        chk("colj_resume_last", get_q(10 + H - 1).addr, H - 1);
        chk("colj_seq_err_sticky", bus.seq_err, 1);
        pulse_fs();
        chk("colj_seq_err_fs", bus.seq_err, 0);

        // Random gaps, mid-line reset, then a full frame against the model
        for (int r = 0; r < 4; r++) for (int c = 0; c < H; c++) img[r][c] = 24'($urandom);
        pulse_fs();
        send_row(0, 3);
        for (int c = 0; c <= 300; c++) send(1, c, int'($urandom_range(2, 0)));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        chk_idle("rst_mid");
        send(1, 301, 0);
        repeat (4) @(negedge clk);
        chk_idle("rst_after");
        chk("rst_no_out", q.size(), 0);
        pulse_fs();
        for (int r = 0; r < 4; r++) send_row(r, 3);
        drain();
        check_frame(4, 1'b0, "rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
